led_mux_sequencer: RTL and testbench

LED_MUX_SEQUENCER -- requirements
Module: led_mux_sequencer

---
 rtl/ppg_pkg.sv | 35 +++
 rtl/phase_timer.sv | 26 ++
 rtl/led_mux_sequencer.sv | 178 +++++++++++++++++
 tb/tb_led_mux_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// ppg_pkg: shared definitions for the LED mux sequencer.
//   state_t        - sequencer FSM states
//   ADC_W/DC_W/... - front-end field widths
//   DC_RST         - DC compensation code driven out of reset / while idle
//   sat_sub        - unsigned subtract clamped at zero
//   is_rail        - true when a raw sample sits on either ADC rail
package ppg_pkg;

  localparam int ADC_W = 8;
  localparam int DC_W  = 7;
  localparam int PGA_W = 4;
  localparam int CNT_W = 8;

  localparam logic [DC_W-1:0] DC_RST = 7'd64;

  typedef enum logic [2:0] {
    IDLE,
    IR_SETTLE,
    IR_SAMPLE,
    RED_SETTLE,
    RED_SAMPLE,
    DARK,
    AMB_SAMPLE
  } state_t;

  function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic is_rail(input logic [ADC_W-1:0] v);
    return (v == '0) || (v == '1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that times the settle and dark phases.
//   clk, rst_n   - clock, async active-low reset
//   i_load       - load i_load_val this edge (takes priority over counting)
//   i_load_val   - count value; interval length is i_load_val+1 cycles
//   o_done       - counter is at zero (last cycle of the interval)
module phase_timer
  import ppg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/led_mux_sequencer.sv
// led_mux_sequencer: time-multiplexes IR and RED LEDs plus an ambient (dark)
// window, programs the analog front end per phase and captures one ADC sample
// per phase. Results are published together once per frame.
//   clk, rst_n                 - clock, async active-low reset
//   enable                     - run request (checked in IDLE and at frame end)
//   DC_IR/DC_RED, PGA_IR/RED   - per-channel front-end codes, latched per frame
//   ADC                        - converter result, valid every cycle
//   LED_IR, LED_RED            - LED drive enables (never both high)
//   DC_Comp, PGA_Gain          - front-end codes for the current phase
//   sample_ir/red/amb          - per-frame results
//   sample_valid               - one-cycle pulse when the results update
//   sat_ir, sat_red            - raw channel sample hit a rail
// Build option: define AMBIENT_SUB_EN to report ir/red as raw minus ambient,
// clamped at zero; otherwise raw values are reported.
module led_mux_sequencer
  import ppg_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DARK_CYC   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DC_W-1:0]  DC_IR,
  input  logic [DC_W-1:0]  DC_RED,
  input  logic [PGA_W-1:0] PGA_IR,
  input  logic [PGA_W-1:0] PGA_RED,
  input  logic [ADC_W-1:0] ADC,
  output logic             LED_IR,
  output logic             LED_RED,
  output logic [DC_W-1:0]  DC_Comp,
  output logic [PGA_W-1:0] PGA_Gain,
  output logic [ADC_W-1:0] sample_ir,
  output logic [ADC_W-1:0] sample_red,
  output logic [ADC_W-1:0] sample_amb,
  output logic             sample_valid,
  output logic             sat_ir,
  output logic             sat_red
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DARK_LD   = CNT_W'(DARK_CYC - 1);

  state_t r_state, w_next;

  logic [DC_W-1:0]  r_dc_ir, r_dc_red;
  logic [PGA_W-1:0] r_pga_ir, r_pga_red;
  logic [ADC_W-1:0] r_raw_ir, r_raw_red;

  logic             w_load, w_done, w_frame_start;
  logic [CNT_W-1:0] w_load_val;
  logic [ADC_W-1:0] w_out_ir, w_out_red;

  phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (enable) w_next = IR_SETTLE;
      IR_SETTLE:  if (w_done) w_next = IR_SAMPLE;
      IR_SAMPLE:  w_next = RED_SETTLE;
      RED_SETTLE: if (w_done) w_next = RED_SAMPLE;
      RED_SAMPLE: w_next = DARK;
      DARK:       if (w_done) w_next = AMB_SAMPLE;
      AMB_SAMPLE: w_next = enable ? IR_SETTLE : IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Timer is reloaded on the edge that enters a timed phase, so the phase's
  // first cycle already sees the full count.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    if (w_next != r_state) begin
      case (w_next)
        IR_SETTLE, RED_SETTLE: begin w_load = 1'b1; w_load_val = SETTLE_LD; end
        DARK:                  begin w_load = 1'b1; w_load_val = DARK_LD;   end
        default: ;
      endcase
    end
  end

  assign w_frame_start = (w_next == IR_SETTLE) && (r_state != IR_SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dc_ir   <= '0;
      r_dc_red  <= '0;
      r_pga_ir  <= '0;
      r_pga_red <= '0;
    end else if (w_frame_start) begin
      r_dc_ir   <= DC_IR;
      r_dc_red  <= DC_RED;
      r_pga_ir  <= PGA_IR;
      r_pga_red <= PGA_RED;
    end
  end

  // Pure decode of the state register: one state at a time means at most one
  // LED, with no overlap at the IR->RED handover.
  always_comb begin
    LED_IR   = 1'b0;
    LED_RED  = 1'b0;
    DC_Comp  = DC_RST;
    PGA_Gain = '0;
    case (r_state)
      IR_SETTLE, IR_SAMPLE: begin
        LED_IR   = 1'b1;
        DC_Comp  = r_dc_ir;
        PGA_Gain = r_pga_ir;
      end
      RED_SETTLE, RED_SAMPLE: begin
        LED_RED  = 1'b1;
        DC_Comp  = r_dc_red;
        PGA_Gain = r_pga_red;
      end
      DARK, AMB_SAMPLE: begin
        DC_Comp  = r_dc_red;
        PGA_Gain = r_pga_red;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw_ir  <= '0;
      r_raw_red <= '0;
    end else begin
      if (r_state == IR_SAMPLE)  r_raw_ir  <= ADC;
      if (r_state == RED_SAMPLE) r_raw_red <= ADC;
    end
  end

`ifdef AMBIENT_SUB_EN
  assign w_out_ir  = sat_sub(r_raw_ir,  ADC);
  assign w_out_red = sat_sub(r_raw_red, ADC);
`else
  assign w_out_ir  = r_raw_ir;
  assign w_out_red = r_raw_red;
`endif

  // Ambient is taken straight from ADC in AMB_SAMPLE so all results land on
  // the following cycle together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_ir    <= '0;
      sample_red   <= '0;
      sample_amb   <= '0;
      sat_ir       <= 1'b0;
      sat_red      <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (r_state == AMB_SAMPLE) begin
        sample_ir    <= w_out_ir;
        sample_red   <= w_out_red;
        sample_amb   <= ADC;
        sat_ir       <= is_rail(r_raw_ir);
        sat_red      <= is_rail(r_raw_red);
        sample_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_mux_sequencer.sv
module tb_led_mux_sequencer;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [6:0] DC_IR = '0, DC_RED = '0;
  logic [3:0] PGA_IR = '0, PGA_RED = '0;
  logic [7:0] ADC = '0;
  logic       LED_IR, LED_RED, sample_valid, sat_ir, sat_red;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] sample_ir, sample_red, sample_amb;

  typedef struct packed {
    logic [7:0] ir;
    logic [7:0] red;
    logic [7:0] amb;
    logic       sir;
    logic       sred;
  } exp_t;

  exp_t q[$];
  exp_t mon_e, mon_got;
  int n_cmp = 0, n_bad = 0, n_valid = 0, n_push = 0;

  led_mux_sequencer #(.SETTLE_CYC(16), .DARK_CYC(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .DC_IR(DC_IR), .DC_RED(DC_RED), .PGA_IR(PGA_IR), .PGA_RED(PGA_RED),
    .ADC(ADC), .LED_IR(LED_IR), .LED_RED(LED_RED),
    .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .sample_ir(sample_ir), .sample_red(sample_red), .sample_amb(sample_amb),
    .sample_valid(sample_valid), .sat_ir(sat_ir), .sat_red(sat_red)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] ir, red, amb);
    exp_t e;
`ifdef AMBIENT_SUB_EN
    e.ir  = (ir  > amb) ? ir  - amb : 8'd0;
    e.red = (red > amb) ? red - amb : 8'd0;
`else
    e.ir  = ir;
    e.red = red;
`endif
    e.amb  = amb;
    e.sir  = (ir  == 8'd0) || (ir  == 8'd255);
    e.sred = (red == 8'd0) || (red == 8'd255);
    return e;
  endfunction

  // Scoreboard: every valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      n_valid++;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL sample_valid_unexpected at %0t", $time);
      end else begin
        mon_e   = q.pop_front();
        mon_got = {sample_ir, sample_red, sample_amb, sat_ir, sat_red};
        if (mon_got !== mon_e) begin
          n_bad++;
          $display("FAIL frame_result got ir=%0d red=%0d amb=%0d sat=%b%b want ir=%0d red=%0d amb=%0d sat=%b%b",
                   sample_ir, sample_red, sample_amb, sat_ir, sat_red,
                   mon_e.ir, mon_e.red, mon_e.amb, mon_e.sir, mon_e.sred);
        end
      end
    end
  end

  // One full frame starting at the edge that enters IR_SETTLE. Checks LED and
  // front-end codes every cycle and drives ADC for each sample slot.
  task automatic run_frame(input logic [7:0] ir, red, amb,
                           input logic [6:0] e_dc_ir, e_dc_red,
                           input logic [3:0] e_pga_ir, e_pga_red,
                           input int chg_k, input logic [6:0] chg_dc,
                           input int drop_k);
    logic [12:0] got, want;
    logic        in_ir, in_red;
    for (int k = 0; k < 67; k++) begin
      @(posedge clk); #1;
      if (k == chg_k)  DC_IR  = chg_dc;
      if (k == drop_k) enable = 1'b0;
      in_ir  = (k <= 16);
      in_red = (k >= 17) && (k <= 33);
      want = {in_ir, in_red, in_ir ? e_dc_ir : e_dc_red, in_ir ? e_pga_ir : e_pga_red};
      got  = {LED_IR, LED_RED, DC_Comp, PGA_Gain};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL phase_outputs k=%0d got led=%b%b dc=%0d pga=%0d want led=%b%b dc=%0d pga=%0d",
                 k, got[12], got[11], got[10:4], got[3:0], want[12], want[11], want[10:4], want[3:0]);
      end
      ADC = (k == 16) ? ir : (k == 33) ? red : (k == 66) ? amb : 8'd77;
      if (k == 66) begin
        q.push_back(mk(ir, red, amb));
        n_push++;
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    logic [48:0] got, want;
    got  = {LED_IR, LED_RED, DC_Comp, PGA_Gain, sample_ir, sample_red, sample_amb,
            sample_valid, sat_ir, sat_red, 8'(dut.r_state)};
    want = {1'b0, 1'b0, 7'd64, 4'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_vals("reset_state");
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_frames();
    @(posedge clk); #1;
    DC_IR = 7'd20; DC_RED = 7'd90; PGA_IR = 4'd3; PGA_RED = 4'd5;
    enable = 1'b1;
    run_frame(8'd100, 8'd100, 8'd100, 7'd20, 7'd90, 4'd3, 4'd5, -1, 7'd0, -1);
    run_frame(8'd200, 8'd150, 8'd40,  7'd20, 7'd90, 4'd3, 4'd5, -1, 7'd0, -1);
    run_frame(8'd30,  8'd30,  8'd60,  7'd20, 7'd90, 4'd3, 4'd5, -1, 7'd0, -1);
    run_frame(8'd255, 8'd128, 8'd10,  7'd20, 7'd90, 4'd3, 4'd5, -1, 7'd0, -1);
    run_frame(8'd128, 8'd0,   8'd5,   7'd20, 7'd90, 4'd3, 4'd5, -1, 7'd0, -1);
  endtask

  task automatic test_dc_shadow();
    run_frame(8'd90, 8'd80, 8'd20, 7'd20, 7'd90, 4'd3, 4'd5, 5, 7'd50, -1);
    run_frame(8'd90, 8'd80, 8'd20, 7'd50, 7'd90, 4'd3, 4'd5, -1, 7'd0, -1);
  endtask

  task automatic test_enable_drop();
    run_frame(8'd120, 8'd70, 8'd30, 7'd50, 7'd90, 4'd3, 4'd5, -1, 7'd0, 40);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({LED_IR, LED_RED} !== 2'b00) begin
        n_bad++;
        $display("FAIL idle_leds cyc=%0d got %b%b want 00", i, LED_IR, LED_RED);
      end
    end
    n_cmp++;
    if (n_valid !== n_push) begin
      n_bad++;
      $display("FAIL valid_count_after_drop got %0d want %0d", n_valid, n_push);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    enable = 1'b1;
    ADC = 8'd55;
    repeat (22) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset_mid_frame");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_held");
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    n_cmp++;
    if (n_valid !== n_push) begin
      n_bad++;
      $display("FAIL valid_count_after_abort got %0d want %0d", n_valid, n_push);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_dc_shadow();
    test_enable_drop();
    test_reset_mid();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
